// File: rtl/obstacle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_pkg
// Brief    : Shared widths, spawn FSM state encoding and obstacle type codes
//            for the scrolling obstacle field.
// Revision : 1.0 - initial release
// ============================================================================
package obstacle_pkg;

    localparam int unsigned c_POS_W  = 9;
    localparam int unsigned c_TYPE_W = 3;

    typedef enum logic [1:0] {
        c_ST_IDLE  = 2'd0,
        c_ST_GAP   = 2'd1,
        c_ST_ARMED = 2'd2
    } spawn_state_t;

    localparam logic [c_TYPE_W-1:0] c_TYPE_CACTUS_SMALL = 3'd0;
    localparam logic [c_TYPE_W-1:0] c_TYPE_CACTUS_LARGE = 3'd1;
    localparam logic [c_TYPE_W-1:0] c_TYPE_CACTUS_GROUP = 3'd2;
    localparam logic [c_TYPE_W-1:0] c_TYPE_BIRD_LOW     = 3'd3;
    localparam logic [c_TYPE_W-1:0] c_TYPE_BIRD_HIGH    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/obstacle_slot.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_slot
// Brief    : One obstacle slot: valid/pos/type registers, scroll and expiry.
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_slot
    import obstacle_pkg::*;
#(
    parameter int unsigned POS_W   = c_POS_W,
    parameter int unsigned TYPE_W  = c_TYPE_W,
    parameter int unsigned SPAWN_X = 319
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_step,
    input  logic [3:0]        i_speed,
    input  logic              i_load,
    input  logic [TYPE_W-1:0] i_load_type,
    output logic              o_valid,
    output logic [POS_W-1:0]  o_pos,
    output logic [TYPE_W-1:0] o_type
);

    localparam logic [POS_W-1:0] c_SPAWN_X = POS_W'(SPAWN_X);

    logic              r_valid;
    logic [POS_W-1:0]  r_pos;
    logic [TYPE_W-1:0] r_type;
    logic [POS_W-1:0]  w_speed_ext;

    assign w_speed_ext = POS_W'(i_speed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pos   <= '0;
            r_type  <= TYPE_W'(c_TYPE_CACTUS_SMALL);
        end else if (i_step) begin
            if (i_load) begin
                r_valid <= 1'b1;
                r_pos   <= c_SPAWN_X;
                r_type  <= i_load_type;
            end else if (r_valid) begin
                // Saturate at the left edge instead of wrapping to a large x
                if (r_pos >= w_speed_ext) begin
                    r_pos <= r_pos - w_speed_ext;
                end else begin
                    r_valid <= 1'b0;
                    r_pos   <= '0;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pos   = r_pos;
    assign o_type  = r_type;

endmodule
`default_nettype wire

// File: rtl/obstacle_field.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_field
// Brief    : Scrolling obstacle slots with a gap/arm spawn FSM and read port.
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_field
    import obstacle_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned POS_W     = c_POS_W,
    parameter int unsigned TYPE_W    = c_TYPE_W,
    parameter int unsigned SPAWN_X   = 319,
    parameter int unsigned GEN_LINE  = 250,
    parameter int unsigned MIN_GAP   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         run,
    input  logic [3:0]                   speed,
    input  logic [7:0]                   rng,
    input  logic [$clog2(NUM_SLOTS)-1:0] rd_sel,
    output logic [POS_W-1:0]             rd_pos,
    output logic [TYPE_W-1:0]            rd_type,
    output logic                         rd_valid,
    output logic [$clog2(NUM_SLOTS):0]   active_cnt,
    output logic                         spawn_pulse
);

    localparam int unsigned        c_SEL_W    = $clog2(NUM_SLOTS);
    localparam int unsigned        c_CNT_W    = c_SEL_W + 1;
    localparam int unsigned        c_GAP_W    = 9;
    localparam logic [c_GAP_W-1:0] c_MIN_GAP  = c_GAP_W'(MIN_GAP);
    localparam logic [POS_W-1:0]   c_GEN_LINE = POS_W'(GEN_LINE);

    logic                 w_step;
    logic [NUM_SLOTS-1:0] w_valid;
    logic [NUM_SLOTS-1:0] w_load;
    logic [POS_W-1:0]     w_pos  [NUM_SLOTS];
    logic [TYPE_W-1:0]    w_type [NUM_SLOTS];
    logic [TYPE_W-1:0]    w_spawn_type;
    logic [POS_W-1:0]     w_speed_ext;
    logic [POS_W-1:0]     w_new_pos;
    logic [POS_W-1:0]     w_new_post;
    logic                 w_new_valid;
    logic                 w_gap_ok;
    logic                 w_free_any;
    logic [c_SEL_W-1:0]   w_free_idx;
    logic [c_CNT_W-1:0]   w_cnt;
    logic                 w_spawn;
    logic [c_GAP_W-1:0]   w_gap_dec;
    logic [c_GAP_W-1:0]   w_gap_nxt;
    logic [c_SEL_W-1:0]   w_newest_nxt;
    spawn_state_t         w_state_nxt;

    spawn_state_t         r_state;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_SEL_W-1:0]   r_newest;
    logic [c_CNT_W-1:0]   r_active_cnt;
    logic                 r_spawn_pulse;

    assign w_step       = tick & run;
    assign w_spawn_type = rng[TYPE_W:1];
    assign w_speed_ext  = POS_W'(speed);

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign w_load[gi] = w_spawn && (w_free_idx == c_SEL_W'(gi));

        obstacle_slot #(
            .POS_W   (POS_W),
            .TYPE_W  (TYPE_W),
            .SPAWN_X (SPAWN_X)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_step      (w_step),
            .i_speed     (speed),
            .i_load      (w_load[gi]),
            .i_load_type (w_spawn_type),
            .o_valid     (w_valid[gi]),
            .o_pos       (w_pos[gi]),
            .o_type      (w_type[gi])
        );
    end

    // Free slots are judged on pre-step valid bits, so a slot expiring this step waits
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_cnt      = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = c_SEL_W'(i);
            end
            w_cnt = w_cnt + c_CNT_W'(w_valid[i]);
        end
    end

    assign w_new_valid = w_valid[r_newest];
    assign w_new_pos   = w_pos[r_newest];
    assign w_new_post  = (w_new_pos >= w_speed_ext) ? (w_new_pos - w_speed_ext) : '0;
    assign w_gap_ok    = !w_new_valid || (w_new_post < c_GEN_LINE);
    assign w_gap_dec   = r_gap_cnt - 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_gap_nxt    = r_gap_cnt;
        w_newest_nxt = r_newest;
        w_spawn      = 1'b0;
        if (run) begin
            case (r_state)
                c_ST_GAP: begin
                    if (w_step) begin
                        w_gap_nxt = w_gap_dec;
                        if (w_gap_dec == '0) begin
                            w_state_nxt = c_ST_ARMED;
                        end
                    end
                end
                c_ST_ARMED: begin
                    if (!w_free_any) begin
                        w_state_nxt = c_ST_IDLE;
                    end else if (w_step && w_gap_ok && rng[0]) begin
                        w_spawn      = 1'b1;
                        w_newest_nxt = w_free_idx;
                        w_gap_nxt    = c_MIN_GAP + c_GAP_W'(rng[7:4]);
                        w_state_nxt  = c_ST_GAP;
                    end
                end
                c_ST_IDLE: begin
                    if (w_free_any) begin
                        w_state_nxt = c_ST_ARMED;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_GAP;
                    w_gap_nxt   = c_MIN_GAP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_GAP;
            r_gap_cnt     <= c_MIN_GAP;
            r_newest      <= '0;
            r_active_cnt  <= '0;
            r_spawn_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gap_cnt     <= w_gap_nxt;
            r_newest      <= w_newest_nxt;
            r_active_cnt  <= w_cnt;
            r_spawn_pulse <= w_spawn;
        end
    end

    // Guard keeps non-power-of-two slot counts from reading past the array
    always_comb begin
        rd_valid = 1'b0;
        rd_pos   = '0;
        rd_type  = '0;
        if (32'(rd_sel) < NUM_SLOTS) begin
            rd_valid = w_valid[rd_sel];
            rd_pos   = w_pos[rd_sel];
            rd_type  = w_type[rd_sel];
        end
    end

    assign active_cnt  = r_active_cnt;
    assign spawn_pulse = r_spawn_pulse;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_field.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_field
// Brief    : Directed scoreboard bench for obstacle_field spawn and scroll.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_field;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       run;
    logic [3:0] speed;
    logic [7:0] rng;
    logic [1:0] rd_sel;
    logic [8:0] rd_pos;
    logic [2:0] rd_type;
    logic       rd_valid;
    logic [2:0] active_cnt;
    logic       spawn_pulse;

    obstacle_field #(
        .NUM_SLOTS (4),
        .POS_W     (9),
        .TYPE_W    (3),
        .SPAWN_X   (319),
        .GEN_LINE  (250),
        .MIN_GAP   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .run         (run),
        .speed       (speed),
        .rng         (rng),
        .rd_sel      (rd_sel),
        .rd_pos      (rd_pos),
        .rd_type     (rd_type),
        .rd_valid    (rd_valid),
        .active_cnt  (active_cnt),
        .spawn_pulse (spawn_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step;
        int slot;
        int pos;
        int typ;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_cnt = 0;
    int   n_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int sl, input int p, input int t);
        exp_t e;
        e.step = s;
        e.slot = sl;
        e.pos  = p;
        e.typ  = t;
        sb_q.push_back(e);
    endtask

    // Monitor: every spawn pulse is matched against the oldest expected spawn
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (spawn_pulse === 1'b1) begin
                n_pulses++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_spawn: got spawn at step %0d, expected none", step_cnt);
                end else begin
                    e = sb_q.pop_front();
                    check("spawn_step",  step_cnt, e.step);
                    check("spawn_valid", rd_valid, 1);
                    check("spawn_pos",   rd_pos,   e.pos);
                    check("spawn_type",  rd_type,  e.typ);
                end
            end
        end
    end

    task automatic do_step(input int idle_cycles);
        @(negedge clk);
        if (sb_q.size() > 0) rd_sel = 2'(sb_q[0].slot);
        tick = 1'b1;
        step_cnt++;
        @(negedge clk);
        tick = 1'b0;
        repeat (idle_cycles) @(negedge clk);
        #3;
    endtask

    task automatic frozen_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        #3;
    endtask

    task automatic expect_slot(input string nm, input int s, input int v, input int p);
        rd_sel = 2'(s);
        #1;
        check({nm, "_valid"}, rd_valid, v);
        check({nm, "_pos"},   rd_pos,   p);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst  = 1'b1;
        tick = 1'b0;
        run  = 1'b0;
        #1;
        check("rst_active_cnt", active_cnt, 0);
        check("rst_spawn_pulse", spawn_pulse, 0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check("rst_rd_valid", rd_valid, 0);
        end
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        step_cnt = 0;
        #3;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int base;
        rst    = 1'b1;
        tick   = 1'b0;
        run    = 1'b0;
        speed  = 4'd0;
        rng    = 8'h00;
        rd_sel = 2'd0;

        // Long run at speed 2: first spawn, filling all slots, IDLE, expiry reuse
        apply_reset();
        run = 1'b1; speed = 4'd2; rng = 8'h01;
        push(9, 0, 319, 0);
        push(44, 1, 319, 0);
        push(79, 2, 319, 0);
        push(114, 3, 319, 0);
        push(170, 0, 319, 0);
        for (int k = 1; k <= 172; k++) begin
            do_step((k <= 12) ? 2 : 0);
            if (k == 10)  expect_slot("p1_scroll", 0, 1, 317);
            if (k == 20)  check("p1_single_pulse", n_pulses, 1);
            if (k == 115) check("p1_full_cnt", active_cnt, 4);
            if (k == 168) expect_slot("p1_old_slot", 0, 1, 1);
            if (k == 169) expect_slot("p1_expired", 0, 0, 0);
        end
        check("p1_queue_empty", sb_q.size(), 0);

        // Freeze: ticks with run=0 must not advance gap counter or positions
        apply_reset();
        run = 1'b1; speed = 4'd2; rng = 8'h01;
        push(9, 0, 319, 0);
        repeat (4) do_step(0);
        run = 1'b0;
        frozen_ticks(20);
        run = 1'b1;
        repeat (9) do_step(0);
        expect_slot("p2_pre_freeze", 0, 1, 311);
        run = 1'b0;
        frozen_ticks(20);
        expect_slot("p2_frozen", 0, 1, 311);
        expect_slot("p2_frozen_s1", 1, 0, 0);
        check("p2_frozen_cnt", active_cnt, 1);
        run = 1'b1;
        do_step(0);
        expect_slot("p2_resume", 0, 1, 309);
        check("p2_queue_empty", sb_q.size(), 0);

        // rng[0]=0 blocks spawning; rng=F3 spawns type 1 and reloads gap to 23
        apply_reset();
        run = 1'b1; speed = 4'd4; rng = 8'h01;
        push(9, 0, 319, 0);
        repeat (9) do_step(0);
        rng = 8'h00;
        repeat (21) do_step(0);
        rng = 8'hF3;
        push(31, 1, 319, 1);
        do_step(0);
        rng = 8'h01;
        push(55, 2, 319, 0);
        repeat (25) do_step(0);
        expect_slot("p3_slot0", 0, 1, 131);
        check("p3_cnt", active_cnt, 3);
        check("p3_queue_empty", sb_q.size(), 0);

        // Speed 0 holds position; slot below speed expires to pos 0
        apply_reset();
        run = 1'b1; speed = 4'd0; rng = 8'h01;
        push(9, 0, 319, 0);
        repeat (9) do_step(0);
        rng = 8'h00;
        do_step(0);
        expect_slot("p4_speed0", 0, 1, 319);
        speed = 4'd15;
        repeat (21) do_step(0);
        expect_slot("p4_near_edge", 0, 1, 4);
        speed = 4'd1;
        do_step(0);
        expect_slot("p4_pos3", 0, 1, 3);
        check("p4_cnt_before", active_cnt, 1);
        speed = 4'd4;
        do_step(0);
        expect_slot("p4_expire", 0, 0, 0);
        check("p4_cnt_lag", active_cnt, 1);
        @(negedge clk);
        #3;
        check("p4_cnt_after", active_cnt, 0);
        check("p4_queue_empty", sb_q.size(), 0);

        // Reset pulse in the middle of a spawn step discards it
        apply_reset();
        run = 1'b1; speed = 4'd2; rng = 8'h01;
        push(9, 0, 319, 0);
        repeat (43) do_step(0);
        base = n_pulses;
        rd_sel = 2'd0;
        @(negedge clk);
        tick = 1'b1;
        step_cnt++;
        #2;
        rst = 1'b1;
        #1;
        check("p5_mid_rd_valid", rd_valid, 0);
        check("p5_mid_cnt", active_cnt, 0);
        check("p5_mid_pulse", spawn_pulse, 0);
        @(negedge clk);
        tick     = 1'b0;
        rst      = 1'b0;
        step_cnt = 0;
        #3;
        push(9, 0, 319, 0);
        repeat (12) do_step(0);
        check("p5_pulses", n_pulses - base, 1);
        check("p5_queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
